// File: rtl/hx8352_pkg.sv
// Shared constants and state encodings for the HX8352 parallel-bus sequencer.
package hx8352_pkg;

  // Pseudo-command: value field is a delay in milliseconds, nothing is written.
  localparam logic [7:0] DELAY_CMD       = 8'hFE;
  // Register index that opens the GRAM write window for pixel streaming.
  localparam logic [7:0] GRAM_WRITE_IDX  = 8'h22;
  // End-of-table marker used by the init-value ROM.
  localparam logic [7:0] CMD_CUSTOM_DONE = 8'hFF;

  typedef enum logic [3:0] {
    S_HWRST_LO,
    S_HWRST_HI,
    S_REQ,
    S_WAIT,
    S_DELAY,
    S_IDX,
    S_DAT,
    S_GRAM_IDX,
    S_RUN,
    S_PX_WR
  } seq_state_t;

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_LOW,
    BW_HIGH
  } bw_phase_t;

  // Chip select is held active while a write is in flight and for the whole pixel mode.
  function automatic logic cs_active(input seq_state_t s);
    return (s == S_IDX) || (s == S_DAT) || (s == S_GRAM_IDX) ||
           (s == S_RUN) || (s == S_PX_WR);
  endfunction

endpackage

// File: rtl/hx8352_bus_write.sv
// Single 8080-style write strobe engine: wr_n low for WR_LOW cycles, then high
// for WR_HIGH cycles with rs/db held so the panel latches on the rising edge.
module hx8352_bus_write
  import hx8352_pkg::*;
#(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rs,
  input  logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        lcd_wr_n,
  output logic        lcd_rs,
  output logic [15:0] lcd_db
);

  localparam int unsigned CMAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH - 1);

  bw_phase_t     phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;

  assign busy = (phase != BW_IDLE);
  assign done = (phase == BW_HIGH) && (cnt == HIGH_LAST);

  // Phase sequencing; a start in the final high cycle chains straight into the next write.
  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    if (start) begin
      phase_n = BW_LOW;
      cnt_n   = '0;
    end else begin
      unique case (phase)
        BW_LOW: begin
          if (cnt == LOW_LAST) begin
            phase_n = BW_HIGH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        BW_HIGH: begin
          if (cnt == HIGH_LAST) begin
            phase_n = BW_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Phase register plus registered pin drivers; rs/db captured only on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= BW_IDLE;
      cnt      <= '0;
      lcd_wr_n <= 1'b1;
      lcd_rs   <= 1'b1;
      lcd_db   <= '0;
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      lcd_wr_n <= (phase_n != BW_LOW);
      if (start) begin
        lcd_rs <= rs;
        lcd_db <= data;
      end
    end
  end

endmodule

// File: rtl/hx8352_bus_sequencer.sv
// HX8352 bus sequencer: panel hardware reset, init pair streaming with delay
// pseudo-commands, GRAM index write, then pixel streaming over one strobe engine.
module hx8352_bus_sequencer
  import hx8352_pkg::*;
#(
  parameter int MS_CYCLES = 50000,
  parameter int RST_MS    = 10,
  parameter int WR_LOW    = 2,
  parameter int WR_HIGH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        init_next,
  input  logic [7:0]  init_cmd,
  input  logic [7:0]  init_value,
  input  logic        init_rdy,
  input  logic        init_finish,
  input  logic        px_valid,
  input  logic [15:0] px_data,
  output logic        px_ready,
  output logic        ready,
  output logic        lcd_rst_n,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic [15:0] lcd_db
);

  localparam int unsigned CW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(MS_CYCLES - 1);
  localparam logic [7:0]    RST_LAST = 8'(RST_MS - 1);

  seq_state_t    state, state_n;
  logic [CW-1:0] cyc, cyc_n, cyc_tick;
  logic [7:0]    ms, ms_n, ms_tick;
  logic [7:0]    value_q, value_n;

  logic          wr_start, wr_rs, wr_busy, wr_done;
  logic [15:0]   wr_data;

  hx8352_bus_write #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_bus_write (
    .clk      (clk),
    .rst      (rst),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .busy     (wr_busy),
    .done     (wr_done),
    .lcd_wr_n (lcd_wr_n),
    .lcd_rs   (lcd_rs),
    .lcd_db   (lcd_db)
  );

  // Next state, timer advance and write-engine mux; writes start on the transition edge
  // into a write state so no idle cycle separates the decision from the strobe.
  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    ms_n     = ms;
    value_n  = value_q;
    wr_start = 1'b0;
    wr_rs    = 1'b1;
    wr_data  = '0;
    cyc_tick = (cyc == CYC_LAST) ? '0 : cyc + 1'b1;
    ms_tick  = ((cyc == CYC_LAST) && (ms != 8'hFF)) ? ms + 8'd1 : ms;
    unique case (state)
      S_HWRST_LO, S_HWRST_HI: begin
        if ((cyc == CYC_LAST) && (ms == RST_LAST)) begin
          state_n = (state == S_HWRST_LO) ? S_HWRST_HI : S_REQ;
          cyc_n   = '0;
          ms_n    = '0;
        end else begin
          cyc_n = cyc_tick;
          ms_n  = ms_tick;
        end
      end
      S_REQ: state_n = S_WAIT;
      S_WAIT: begin
        if (init_rdy) begin
          value_n = init_value;
          if (init_cmd == DELAY_CMD) begin
            state_n = S_DELAY;
            cyc_n   = '0;
            ms_n    = '0;
          end else begin
            state_n  = S_IDX;
            wr_start = 1'b1;
            wr_rs    = 1'b0;
            wr_data  = {8'h00, init_cmd};
          end
        end else if (init_finish) begin
          state_n  = S_GRAM_IDX;
          wr_start = 1'b1;
          wr_rs    = 1'b0;
          wr_data  = {8'h00, GRAM_WRITE_IDX};
        end
      end
      S_DELAY: begin
        if ((value_q == 8'd0) || ((cyc == CYC_LAST) && (ms == value_q - 8'd1))) begin
          state_n = S_REQ;
          cyc_n   = '0;
          ms_n    = '0;
        end else begin
          cyc_n = cyc_tick;
          ms_n  = ms_tick;
        end
      end
      S_IDX: begin
        if (wr_done) begin
          state_n  = S_DAT;
          wr_start = 1'b1;
          wr_rs    = 1'b1;
          wr_data  = {8'h00, value_q};
        end
      end
      S_DAT:      if (wr_done) state_n = S_REQ;
      S_GRAM_IDX: if (wr_done) state_n = S_RUN;
      S_RUN: begin
        if (px_valid && px_ready && !wr_busy) begin
          state_n  = S_PX_WR;
          wr_start = 1'b1;
          wr_rs    = 1'b1;
          wr_data  = px_data;
        end
      end
      S_PX_WR:    if (wr_done) state_n = S_RUN;
      default:    state_n = S_HWRST_LO;
    endcase
  end

  // State, timer and registered control outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HWRST_LO;
      cyc       <= '0;
      ms        <= '0;
      value_q   <= '0;
      init_next <= 1'b0;
      px_ready  <= 1'b0;
      ready     <= 1'b0;
      lcd_rst_n <= 1'b0;
      lcd_cs_n  <= 1'b1;
    end else begin
      state     <= state_n;
      cyc       <= cyc_n;
      ms        <= ms_n;
      value_q   <= value_n;
      init_next <= (state_n == S_REQ);
      px_ready  <= (state_n == S_RUN);
      ready     <= ready | (state_n == S_RUN);
      lcd_rst_n <= (state_n != S_HWRST_LO);
      lcd_cs_n  <= !cs_active(state_n);
    end
  end

endmodule

// File: tb/tb_hx8352_bus_sequencer.sv
// Directed bench for hx8352_bus_sequencer with MS_CYCLES=10, RST_MS=1, WR_LOW=WR_HIGH=2.
module tb_hx8352_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_next;
  logic [7:0]  init_cmd = '0;
  logic [7:0]  init_value = '0;
  logic        init_rdy = 1'b0;
  logic        init_finish = 1'b0;
  logic        px_valid = 1'b0;
  logic [15:0] px_data = '0;
  logic        px_ready, ready, lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n;
  logic [15:0] lcd_db;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  val;
    logic        fin;
    int unsigned n_wr;
    logic [15:0] db0;
    logic [15:0] db1;
    int unsigned gap;
  } pair_vec_t;

  typedef struct {
    int unsigned fall;
    logic        rs;
    logic [15:0] db;
    logic        cs_n;
    int unsigned low;
    logic        held;
  } wr_rec_t;

  wr_rec_t wq[$];
  wr_rec_t cur;
  logic    prev_wr = 1'b1;

  always #5 clk = ~clk;

  // Cycle index: equals k at the sample following the k-th edge after rst release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  hx8352_bus_sequencer #(
    .MS_CYCLES (10),
    .RST_MS    (1),
    .WR_LOW    (2),
    .WR_HIGH   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init_next   (init_next),
    .init_cmd    (init_cmd),
    .init_value  (init_value),
    .init_rdy    (init_rdy),
    .init_finish (init_finish),
    .px_valid    (px_valid),
    .px_data     (px_data),
    .px_ready    (px_ready),
    .ready       (ready),
    .lcd_rst_n   (lcd_rst_n),
    .lcd_cs_n    (lcd_cs_n),
    .lcd_rs      (lcd_rs),
    .lcd_wr_n    (lcd_wr_n),
    .lcd_db      (lcd_db)
  );

  // Bus monitor: records each completed wr_n low pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b1;
    end else begin
      if (prev_wr && !lcd_wr_n) begin
        cur.fall = cyc;
        cur.rs   = lcd_rs;
        cur.db   = lcd_db;
        cur.cs_n = lcd_cs_n;
      end else if (!prev_wr && lcd_wr_n) begin
        cur.low  = cyc - cur.fall;
        cur.held = (lcd_rs == cur.rs) && (lcd_db == cur.db);
        wq.push_back(cur);
      end
      prev_wr = lcd_wr_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_init_next(output int unsigned at);
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (!init_next && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("init_next_seen", 32'(init_next), 32'd1);
    at = cyc;
  endtask

  // Expects rst to have just been released at a falling edge.
  task automatic reset_seq_check();
    logic [22:0] e;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = {(k == 20), 1'b0, 1'b0, (k >= 10), 1'b1, 1'b1, 1'b1, 16'h0000};
      chk($sformatf("rstseq_c%0d", k),
          32'({init_next, px_ready, ready, lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_db}),
          32'(e));
    end
  endtask

  initial begin
    pair_vec_t   vecs[4];
    logic [15:0] pix[3];
    int unsigned hs[3];
    int unsigned n, m, r, k;
    logic [15:0] exp_db;

    vecs[0] = '{cmd: 8'h02, val: 8'h3C, fin: 1'b0, n_wr: 2, db0: 16'h0002, db1: 16'h003C, gap: 10};
    vecs[1] = '{cmd: 8'hFE, val: 8'h03, fin: 1'b0, n_wr: 0, db0: 16'h0000, db1: 16'h0000, gap: 32};
    vecs[2] = '{cmd: 8'hFE, val: 8'h00, fin: 1'b0, n_wr: 0, db0: 16'h0000, db1: 16'h0000, gap: 3};
    vecs[3] = '{cmd: 8'h10, val: 8'hA5, fin: 1'b1, n_wr: 2, db0: 16'h0010, db1: 16'h00A5, gap: 10};
    pix[0] = 16'hF800;
    pix[1] = 16'h07E0;
    pix[2] = 16'h001F;

    repeat (3) @(negedge clk);
    chk("reset_state",
        32'({init_next, px_ready, ready, lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_db}),
        32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000}));
    rst = 1'b0;
    reset_seq_check();
    n = cyc;

    // Init pairs; the last one raises init_finish together with init_rdy.
    for (int i = 0; i < 4; i++) begin
      wq.delete();
      @(negedge clk);
      init_cmd    = vecs[i].cmd;
      init_value  = vecs[i].val;
      init_rdy    = 1'b1;
      init_finish = vecs[i].fin;
      @(negedge clk);
      init_rdy = 1'b0;
      wait_init_next(m);
      chk($sformatf("v%0d_gap", i), m - n, vecs[i].gap);
      chk($sformatf("v%0d_nwr", i), 32'(wq.size()), vecs[i].n_wr);
      for (int j = 0; j < int'(vecs[i].n_wr) && j < wq.size(); j++) begin
        exp_db = (j == 0) ? vecs[i].db0 : vecs[i].db1;
        chk($sformatf("v%0d_w%0d_db", i, j), 32'(wq[j].db), 32'(exp_db));
        chk($sformatf("v%0d_w%0d_rs", i, j), 32'(wq[j].rs), 32'(j != 0));
        chk($sformatf("v%0d_w%0d_cs", i, j), 32'(wq[j].cs_n), 32'd0);
        chk($sformatf("v%0d_w%0d_low", i, j), wq[j].low, 32'd2);
        chk($sformatf("v%0d_w%0d_held", i, j), 32'(wq[j].held), 32'd1);
        chk($sformatf("v%0d_w%0d_fall", i, j), wq[j].fall - n, (j == 0) ? 32'd2 : 32'd6);
      end
      n = m;
    end

    // init_finish still high: GRAM index write, then pixel mode.
    wq.delete();
    px_data  = pix[0];
    px_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    r = cyc;
    chk("gram_ready", 32'(ready), 32'd1);
    chk("gram_ready_cycle", r - n, 32'd6);
    chk("gram_px_ready", 32'(px_ready), 32'd1);
    chk("gram_cs_n", 32'(lcd_cs_n), 32'd0);
    chk("gram_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      chk("gram_db", 32'(wq[0].db), 32'h0022);
      chk("gram_rs", 32'(wq[0].rs), 32'd0);
      chk("gram_low", wq[0].low, 32'd2);
      chk("gram_fall", wq[0].fall - n, 32'd2);
    end

    wq.delete();
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!px_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("px%0d_ready", i), 32'(px_ready), 32'd1);
      chk($sformatf("px%0d_cs_n", i), 32'(lcd_cs_n), 32'd0);
      hs[i] = cyc + 1;
      @(negedge clk);
      chk($sformatf("px%0d_busy_ready", i), 32'(px_ready), 32'd0);
      if (i < 2) px_data = pix[i+1];
      else       px_valid = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("px_nwr", 32'(wq.size()), 32'd3);
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      chk($sformatf("px%0d_db", i), 32'(wq[i].db), 32'(pix[i]));
      chk($sformatf("px%0d_rs", i), 32'(wq[i].rs), 32'd1);
      chk($sformatf("px%0d_wcs", i), 32'(wq[i].cs_n), 32'd0);
      chk($sformatf("px%0d_low", i), wq[i].low, 32'd2);
      chk($sformatf("px%0d_held", i), 32'(wq[i].held), 32'd1);
      chk($sformatf("px%0d_fall", i), wq[i].fall, hs[i]);
    end
    chk("px_first_hs", hs[0] - r, 32'd1);
    chk("px_spacing01", hs[1] - hs[0], 32'd5);
    chk("px_spacing12", hs[2] - hs[1], 32'd5);
    chk("px_idle", 32'({px_ready, lcd_cs_n, lcd_wr_n, ready}), 32'b1011);

    // Reset abort in the low phase of a pixel write.
    px_data  = 16'h1234;
    px_valid = 1'b1;
    k = 0;
    while (!px_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("abort_wr_low", 32'(lcd_wr_n), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outputs",
        32'({init_next, px_ready, ready, lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_db}),
        32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000}));
    @(negedge clk);
    rst         = 1'b0;
    px_valid    = 1'b0;
    init_finish = 1'b0;
    init_cmd    = '0;
    init_value  = '0;
    reset_seq_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
